conversor_bcd_secuencial: RTL and testbench
===========================================

# conversor_bcd_secuencial

Sequential binary-to-BCD converter that sits directly downstream of the algorithmic divider. It takes one signed two's-complement result word (quotient or remainder) on a Start pulse, typically the divider's Done. It converts the magnitude to packed BCD with shift-and-add-3 (double dabble), one bit per two cycles, and presents the digits plus a sign flag for the display stage.

## Interface
- tamanyo, 32: input word width in bits, same value as the divider's tamanyo.
- N_DIG, 10: number of BCD output digits. Must satisfy N_DIG ≥ ceil(tamanyo·log10 2) + (tamanyo ≥ 4 ? 0 : 1); a simulation assertion fires otherwise.
- t_mod, 6: bit-counter width. Must satisfy 2^t_mod > tamanyo.
- CLK  in  1: single clock, rising edge.
- RSTa  in  1: reset, synchronous and active-low. Sampled on CLK rising edge.
- Start  in  1: conversion request, sampled only in IDLE.
- Dato  in  tamanyo: value to convert, two's complement. Sampled on the accepting edge only.
- BCD  out  4·N_DIG: packed digits, digit 0 (units) in bits [3:0].
- Signo  out  1: 1 = result negative.
- Done  out  1: one-cycle pulse, BCD/Signo newly valid.
- Busy  out  1: conversion in progress.

## Operation
- States: IDLE, AJUSTE, DESPL.
- IDLE, Start=1:
  - MAG ← Dato[tamanyo-1] ? (~Dato+1) : Dato, treated as unsigned.
  - SIGN_R ← Dato[tamanyo-1].
  - ACC (4·N_DIG bits) ← 0.
  - CONT ← tamanyo.
  - Busy ← 1.
  - Next state AJUSTE.
- IDLE, Start=0: hold. Done ← 0.
- AJUSTE: every ACC digit ≥ 5 gets +3, all digits in parallel, no inter-digit carry. Next state DESPL.
- DESPL: {ACC, MAG} ← {ACC, MAG} << 1; CONT ← CONT−1.
  - CONT≠1: next state AJUSTE.
  - CONT=1 (last bit): BCD ← shifted ACC, Signo ← SIGN_R, Done ← 1, Busy ← 0, next state IDLE.
- BCD and Signo hold their last value until the next completion. They never show partial results.
- Most-negative input (0x80000000 for 32 bits): the magnitude is correct as unsigned 2^(tamanyo-1), Signo=1.
- Zero input: Signo=0, even if the sign bit path is exercised.
- Start while Busy: ignored, not queued.
- Start high during the Done cycle: accepted, because the state is IDLE. Back-to-back conversions are supported.
- Reset (RSTa=0 at an edge), including mid-conversion:
  - state ← IDLE.
  - BCD ← 0, Signo ← 0, Done ← 0, Busy ← 0.
  - MAG/ACC/CONT ← 0.
  - An aborted conversion never produces Done.

## Timing
- Start sampled at edge E:
  - Busy high after E.
  - BCD/Signo updated and Done high after edge E+2·tamanyo. That is 64 cycles for tamanyo=32.
  - Done low again after E+2·tamanyo+1 unless a new conversion completes.
- Throughput: one conversion per 2·tamanyo cycles with back-to-back Start.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- Macro CONVERSOR_SIGNO_EN.
- Defined: signed handling as described above.
- Undefined:
  - Dato is treated as unsigned, with no negation logic.
  - SIGN_R is not generated and Signo is tied to 0.
  - N_DIG must cover 2^tamanyo−1 (10 digits for 32 bits).

## Structure
- Shared package divisor_pkg holds:
  - the state enum typedef (IDLE, AJUSTE, DESPL);
  - the constant BCD_AJUSTE = 4'd3;
  - the function n_digitos(tamanyo), returning the minimum N_DIG. It is used by the assertion and by the top level.
- One natural sub-module: ajuste_bcd.
  - Combinational, parameterised by N_DIG.
  - Applies add-3 to each digit ≥ 5.
  - Instantiated once and used in AJUSTE.

## Test plan
- Dato=0 → after 64 cycles BCD=0x0000000000, Signo=0, Done single pulse, Busy high for exactly 64 cycles.
- Dato=12345 → BCD=0x0000012345, Signo=0. Dato=−7 (0xFFFFFFF9) → BCD=0x0000000007, Signo=1.
- Dato=0x80000000:
  - macro defined → BCD=0x2147483648, Signo=1;
  - macro undefined → BCD=0x2147483648, Signo=0.
  - Dato=0xFFFFFFFF, macro undefined → BCD=0x4294967295.
- Start=1 with Dato=99 accepted, then Start pulses at cycles 10 and 30 with Dato=5 → only one Done, BCD=0x0000000099. A second Start given in the Done cycle with Dato=−100 → next Done 64 cycles later, BCD=0x0000000100, Signo=1.
- Reset asserted at cycle 20 of a conversion of 555 → Busy=0, Done=0, BCD=0, Signo=0 from the next edge. No Done appears. A fresh conversion of 555 then completes normally with BCD=0x0000000555.

Source files
------------

// File: rtl/divisor_pkg.sv
// Types and constants shared by the divider datapath and the sequential BCD converter.
package divisor_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        AJUSTE = 2'd1,
        DESPL  = 2'd2
    } estado_t;

    localparam logic [3:0] BCD_AJUSTE = 4'd3;

    // Minimum BCD digits for a tamanyo-bit word: ceil(tamanyo*log10(2)), plus one for tiny widths.
    function automatic int n_digitos(input int tam);
        int base;
        base = (tam * 30103 + 99999) / 100000;
        return base + ((tam >= 4) ? 0 : 1);
    endfunction

endpackage

// File: rtl/conversor_bcd_ajuste_bcd.sv
// Double-dabble adjust step: every packed BCD digit >= 5 gets +3, digits independent.
module ajuste_bcd #(
    parameter int N_DIG = 10
) (
    input  logic [4*N_DIG-1:0] acc_i,
    output logic [4*N_DIG-1:0] acc_o
);
    import divisor_pkg::*;

    logic [N_DIG-1:0][3:0] dig_in;
    logic [N_DIG-1:0][3:0] dig_out;

    assign dig_in = acc_i;

    for (genvar g = 0; g < N_DIG; g++) begin : g_dig
        // No carry into the next digit: an adjusted digit is at most 12, still 4 bits.
        assign dig_out[g] = (dig_in[g] >= 4'd5) ? (dig_in[g] + BCD_AJUSTE) : dig_in[g];
    end

    assign acc_o = dig_out;

endmodule

// File: rtl/conversor_bcd_secuencial.sv
// Sequential binary-to-BCD converter (double dabble, one bit every two cycles).
// CONVERSOR_SIGNO_EN: when defined, Dato is two's complement and Signo reports the sign.
module conversor_bcd_secuencial #(
    parameter int tamanyo = 32,
    parameter int N_DIG   = 10,
    parameter int t_mod   = 6
) (
    input  logic                 CLK,
    input  logic                 RSTa,
    input  logic                 Start,
    input  logic [tamanyo-1:0]   Dato,
    output logic [4*N_DIG-1:0]   BCD,
    output logic                 Signo,
    output logic                 Done,
    output logic                 Busy
);
    import divisor_pkg::*;

    localparam int MIN_DIG = n_digitos(tamanyo);
    localparam int ACC_W   = 4 * N_DIG;

    estado_t              estado_q, estado_d;
    logic [tamanyo-1:0]   mag_q, mag_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [t_mod-1:0]     cont_q, cont_d;
    logic [ACC_W-1:0]     bcd_q, bcd_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic [ACC_W-1:0]     acc_adj;
    logic [ACC_W-1:0]     acc_sh;
    logic [tamanyo-1:0]   mag_in;

    assert property (@(posedge CLK) (N_DIG >= MIN_DIG) && ((2 ** t_mod) > tamanyo));

    ajuste_bcd #(.N_DIG(N_DIG)) u_ajuste (
        .acc_i (acc_q),
        .acc_o (acc_adj)
    );

    assign acc_sh = {acc_q[ACC_W-2:0], mag_q[tamanyo-1]};

`ifdef CONVERSOR_SIGNO_EN
    logic sign_r_q, sign_r_d;
    logic signo_q, signo_d;

    // Most-negative input negates to itself, which is the correct unsigned magnitude.
    assign mag_in = Dato[tamanyo-1] ? (~Dato + 1'b1) : Dato;
    assign Signo  = signo_q;
`else
    assign mag_in = Dato;
    assign Signo  = 1'b0;
`endif

    always_comb begin
        estado_d = estado_q;
        mag_d    = mag_q;
        acc_d    = acc_q;
        cont_d   = cont_q;
        bcd_d    = bcd_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
`ifdef CONVERSOR_SIGNO_EN
        sign_r_d = sign_r_q;
        signo_d  = signo_q;
`endif
        case (estado_q)
            IDLE: begin
                if (Start) begin
                    mag_d    = mag_in;
                    acc_d    = '0;
                    cont_d   = t_mod'(tamanyo);
                    busy_d   = 1'b1;
                    estado_d = AJUSTE;
`ifdef CONVERSOR_SIGNO_EN
                    sign_r_d = Dato[tamanyo-1];
`endif
                end
            end
            AJUSTE: begin
                acc_d    = acc_adj;
                estado_d = DESPL;
            end
            DESPL: begin
                acc_d  = acc_sh;
                mag_d  = {mag_q[tamanyo-2:0], 1'b0};
                cont_d = cont_q - 1'b1;
                if (cont_q == t_mod'(1)) begin
                    bcd_d    = acc_sh;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    estado_d = IDLE;
`ifdef CONVERSOR_SIGNO_EN
                    signo_d  = sign_r_q;
`endif
                end else begin
                    estado_d = AJUSTE;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTa) begin
            estado_q <= IDLE;
            mag_q    <= '0;
            acc_q    <= '0;
            cont_q   <= '0;
            bcd_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef CONVERSOR_SIGNO_EN
            sign_r_q <= 1'b0;
            signo_q  <= 1'b0;
`endif
        end else begin
            estado_q <= estado_d;
            mag_q    <= mag_d;
            acc_q    <= acc_d;
            cont_q   <= cont_d;
            bcd_q    <= bcd_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef CONVERSOR_SIGNO_EN
            sign_r_q <= sign_r_d;
            signo_q  <= signo_d;
`endif
        end
    end

    assign BCD  = bcd_q;
    assign Done = done_q;
    assign Busy = busy_q;

endmodule

// File: tb/tb_conversor_bcd_secuencial.sv
// Scoreboard bench for conversor_bcd_secuencial; expectations follow CONVERSOR_SIGNO_EN.
module tb_conversor_bcd_secuencial;

    localparam int TAM = 32;
    localparam int ND  = 10;
`ifdef CONVERSOR_SIGNO_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            RSTa;
    logic            Start;
    logic [TAM-1:0]  Dato;
    logic [4*ND-1:0] BCD;
    logic            Signo, Done, Busy;

    typedef struct packed {
        logic [4*ND-1:0] bcd;
        logic            s;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    conversor_bcd_secuencial #(.tamanyo(TAM), .N_DIG(ND), .t_mod(6)) dut (
        .CLK   (CLK),
        .RSTa  (RSTa),
        .Start (Start),
        .Dato  (Dato),
        .BCD   (BCD),
        .Signo (Signo),
        .Done  (Done),
        .Busy  (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every Done pops one expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (Done === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got BCD %0h, expected no Done", BCD);
                end else begin
                    e = q.pop_front();
                    check("bcd", 64'(BCD), 64'(e.bcd));
                    check("signo", 64'(Signo), 64'(e.s));
                end
            end
        end
    end

    task automatic start_conv(input logic [TAM-1:0] d, input logic [4*ND-1:0] eb,
                              input bit es, input bit expect_done);
        @(negedge CLK);
        Start = 1'b1;
        Dato  = d;
        if (expect_done) q.push_back('{bcd: eb, s: es});
        @(negedge CLK);
        Start = 1'b0;
    endtask

    // Called on the first negedge after the accepting edge; lat = edges since acceptance.
    task automatic wait_done(output int lat);
        lat = 0;
        while (Done !== 1'b1 && lat < 200) begin
            @(negedge CLK);
            lat++;
        end
        if (Done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no Done after %0d cycles, expected 64", lat);
        end
    endtask

    initial begin
        int lat, nbusy;
        RSTa  = 1'b0;
        Start = 1'b0;
        Dato  = '0;
        repeat (3) @(negedge CLK);
        check("rst_bcd", 64'(BCD), 64'd0);
        check("rst_signo", 64'(Signo), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        RSTa = 1'b1;

        // Zero: Busy exactly 64 cycles, single Done pulse.
        start_conv(32'd0, 40'h0, 1'b0, 1'b1);
        nbusy = 0;
        while (Busy === 1'b1 && nbusy < 200) begin
            nbusy++;
            @(negedge CLK);
        end
        check("busy_cycles", 64'(nbusy), 64'd64);
        check("done_at_busy_fall", 64'(Done), 64'd1);
        @(negedge CLK);
        check("done_one_pulse", 64'(Done), 64'd0);

        start_conv(32'd12345, 40'h0000012345, 1'b0, 1'b1);
        wait_done(lat);
        check("lat_12345", 64'(lat), 64'd64);

        start_conv(32'hFFFFFFF9, SGN ? 40'h0000000007 : 40'h4294967289, SGN, 1'b1);
        wait_done(lat);

        start_conv(32'h80000000, 40'h2147483648, SGN, 1'b1);
        wait_done(lat);

        start_conv(32'hFFFFFFFF, SGN ? 40'h0000000001 : 40'h4294967295, SGN, 1'b1);
        wait_done(lat);

        // Start while busy is ignored; Start in the Done cycle is accepted.
        start_conv(32'd99, 40'h0000000099, 1'b0, 1'b1);
        repeat (9) @(negedge CLK);
        Start = 1'b1; Dato = 32'd5;
        @(negedge CLK);
        Start = 1'b0;
        repeat (19) @(negedge CLK);
        Start = 1'b1; Dato = 32'd5;
        @(negedge CLK);
        Start = 1'b0;
        while (Done !== 1'b1 && lat < 400) begin
            @(negedge CLK);
            lat++;
        end
        check("done_99_seen", 64'(Done), 64'd1);
        Start = 1'b1;
        Dato  = 32'hFFFFFF9C;
        q.push_back('{bcd: (SGN ? 40'h0000000100 : 40'h4294967196), s: SGN});
        @(negedge CLK);
        Start = 1'b0;
        check("b2b_busy", 64'(Busy), 64'd1);
        wait_done(lat);
        check("lat_b2b", 64'(lat), 64'd64);

        // Reset mid-conversion aborts without Done.
        start_conv(32'd555, 40'h0, 1'b0, 1'b0);
        repeat (19) @(negedge CLK);
        RSTa = 1'b0;
        @(negedge CLK);
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_done", 64'(Done), 64'd0);
        check("abort_bcd", 64'(BCD), 64'd0);
        check("abort_signo", 64'(Signo), 64'd0);
        RSTa = 1'b1;
        repeat (80) @(negedge CLK);

        start_conv(32'd555, 40'h0000000555, 1'b0, 1'b1);
        wait_done(lat);
        check("lat_555", 64'(lat), 64'd64);
        repeat (3) @(negedge CLK);
        check("scoreboard_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
